// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency: fixed WIDTH+2 cycles from accepting edge back to IDLE; result and done at edge t+WIDTH+1.
// Backpressure: busy is high outside IDLE and start is ignored; flush aborts without done or result update.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;          // multiplicand, or dividend shifted out MSB first
  logic [WIDTH-1:0]     b_q, b_d;          // multiplier shifted out LSB first, or divisor
  logic [WIDTH-1:0]     orig_a_q, orig_a_d;
  logic                 neg_q, neg_d;
  logic                 dz_q, dz_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // product, or {remainder, quotient}
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 done_q, done_d;

  logic                 a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH:0]       sum, shifted;
  logic [WIDTH-1:0]     rem_n;
  logic                 q_bit;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s, fix_val;

  // Next-state logic: operand capture, one iteration per CALC cycle, sign fix-up and selection in FIX
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    orig_a_d = orig_a_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    // MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed & opA[WIDTH-1];
    b_neg    = b_signed & opB[WIDTH-1];

    // One shift-add step: add multiplicand when the current multiplier bit is set, then shift right
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};

    // One restoring-divide step: bring in the next dividend bit and subtract if it fits
    shifted  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    q_bit    = (shifted >= {1'b0, b_q});
    rem_n    = q_bit ? WIDTH'(shifted - {1'b0, b_q}) : shifted[WIDTH-1:0];

    // Sign application; overflow (most-negative / -1) falls out of the magnitude path untouched
    prod_s   = neg_q ? -acc_q : acc_q;
    quo_s    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s    = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:                 fix_val = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_val = dz_q ? {WIDTH{1'b1}} : quo_s;
      default:                fix_val = dz_q ? orig_a_q : rem_s;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          a_d      = a_neg ? -opA : opA;
          b_d      = b_neg ? -opB : opB;
          orig_a_d = opA;
          neg_d    = op[2] & op[1] ? a_neg : (a_neg ^ b_neg);
          dz_d     = (opB == {WIDTH{1'b0}});
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (!op_q[2]) begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end else begin
          acc_d = {rem_n, acc_q[WIDTH-2:0], q_bit};
          a_d   = a_q << 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        result_d = fix_val;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a start presented in IDLE
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
      done_d   = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      orig_a_q <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      orig_a_q <= orig_a_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
